// File: rtl/fpu_32_result_stage.sv
// Result stage behind the 32-bit FP adder: special-value fix-up, 2-entry skid buffer,
// sticky exception bits and a delivered-result counter.
module fpu_32_result_stage #(
    parameter bit          FLUSH_UNDERFLOW = 1'b1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_result,
    input  logic                 in_overflow,
    input  logic                 in_underflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [1:0]           out_flags,
    output logic                 sticky_overflow,
    output logic                 sticky_underflow,
    input  logic                 clear_sticky,
    output logic [CNT_WIDTH-1:0] result_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e               state_q, state_d;
    logic [31:0]          out_result_q, skid_result_q;
    logic [1:0]           out_flags_q, skid_flags_q;
    logic                 sticky_ovf_q, sticky_ovf_d;
    logic                 sticky_unf_q, sticky_unf_d;
    logic [CNT_WIDTH-1:0] count_q;

    logic        accept, deliver;
    logic        load_out_in, load_out_skid, load_skid;
    logic [31:0] fix_result;

    // Handshake readiness depends only on registered state.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // Overflow takes priority over underflow when both flags are raised.
    always_comb begin
        fix_result = in_result;
        if (in_overflow) begin
            fix_result = {in_result[31], 8'hFF, 23'h0};
        end else if (in_underflow && FLUSH_UNDERFLOW) begin
            fix_result = {in_result[31], 31'h0};
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    load_out_in = 1'b1;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (deliver) begin
                    state_d       = StOne;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_q <= 32'h0;
            out_flags_q  <= 2'b00;
        end else if (load_out_in) begin
            out_result_q <= fix_result;
            out_flags_q  <= {in_overflow, in_underflow};
        end else if (load_out_skid) begin
            out_result_q <= skid_result_q;
            out_flags_q  <= skid_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_result_q <= 32'h0;
            skid_flags_q  <= 2'b00;
        end else if (load_skid) begin
            skid_result_q <= fix_result;
            skid_flags_q  <= {in_overflow, in_underflow};
        end
    end

    // A set in the same cycle as a clear wins.
    assign sticky_ovf_d = (sticky_ovf_q && !clear_sticky) || (accept && in_overflow);
    assign sticky_unf_d = (sticky_unf_q && !clear_sticky) || (accept && in_underflow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (deliver) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign out_result       = out_result_q;
    assign out_flags        = out_flags_q;
    assign sticky_overflow  = sticky_ovf_q;
    assign sticky_underflow = sticky_unf_q;
    assign result_count     = count_q;

endmodule

// File: tb/tb_fpu_32_result_stage.sv
// Bench for fpu_32_result_stage: a flushing 4-bit-counter instance and a non-flushing
// 16-bit-counter instance share stimulus and are checked against a queue model.
module tb_fpu_32_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_overflow, in_underflow, out_ready, clear_sticky;
    logic [31:0] in_result;

    logic        a_in_ready, a_out_valid, a_sto, a_stu;
    logic [31:0] a_out_result;
    logic [1:0]  a_out_flags;
    logic [3:0]  a_count;

    logic        b_in_ready, b_out_valid, b_sto, b_stu;
    logic [31:0] b_out_result;
    logic [1:0]  b_out_flags;
    logic [15:0] b_count;

    int checks = 0;
    int errors = 0;

    // Model state: FIFO of raw {ovf, unf, result}, sticky bits, delivery count.
    logic [33:0] mq[$];
    int          mcnt;
    logic        msto, mstu;
    logic        macc, mdel;

    always #5 clk = ~clk;

    fpu_32_result_stage #(.FLUSH_UNDERFLOW(1'b1), .CNT_WIDTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
        .out_flags(a_out_flags), .sticky_overflow(a_sto), .sticky_underflow(a_stu),
        .clear_sticky(clear_sticky), .result_count(a_count)
    );

    fpu_32_result_stage #(.FLUSH_UNDERFLOW(1'b0), .CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
        .out_flags(b_out_flags), .sticky_overflow(b_sto), .sticky_underflow(b_stu),
        .clear_sticky(clear_sticky), .result_count(b_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fix(input logic [33:0] e, input bit flush);
        if (e[33]) return {e[31], 8'hFF, 23'h0};
        if (e[32] && flush) return {e[31], 31'h0};
        return e[31:0];
    endfunction

    task automatic put(input logic v, input logic [31:0] r, input logic o, input logic u,
                       input logic ordy, input logic clr);
        @(negedge clk);
        #1;
        in_valid     = v;
        in_result    = r;
        in_overflow  = o;
        in_underflow = u;
        out_ready    = ordy;
        clear_sticky = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: updates on every clock edge from the FIFO rules alone.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mcnt = 0;
                msto = 1'b0;
                mstu = 1'b0;
            end else begin
                macc = in_valid && (mq.size() < 2);
                mdel = out_ready && (mq.size() > 0);
                if (macc && in_overflow) msto = 1'b1;
                else if (clear_sticky) msto = 1'b0;
                if (macc && in_underflow) mstu = 1'b1;
                else if (clear_sticky) mstu = 1'b0;
                if (mdel) begin
                    void'(mq.pop_front());
                    mcnt++;
                end
                if (macc) mq.push_back({in_overflow, in_underflow, in_result});
            end
        end
    end

    // Compare process: every falling edge while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("a_in_ready", 32'(a_in_ready), 32'(mq.size() < 2));
                check("b_in_ready", 32'(b_in_ready), 32'(mq.size() < 2));
                check("a_out_valid", 32'(a_out_valid), 32'(mq.size() > 0));
                check("b_out_valid", 32'(b_out_valid), 32'(mq.size() > 0));
                if (mq.size() > 0) begin
                    check("a_out_result", a_out_result, fix(mq[0], 1'b1));
                    check("b_out_result", b_out_result, fix(mq[0], 1'b0));
                    check("a_out_flags", 32'(a_out_flags), 32'(mq[0][33:32]));
                    check("b_out_flags", 32'(b_out_flags), 32'(mq[0][33:32]));
                end
                check("a_sticky_ovf", 32'(a_sto), 32'(msto));
                check("a_sticky_unf", 32'(a_stu), 32'(mstu));
                check("b_sticky_ovf", 32'(b_sto), 32'(msto));
                check("b_sticky_unf", 32'(b_stu), 32'(mstu));
                check("a_count", 32'(a_count), 32'(mcnt % 16));
                check("b_count", 32'(b_count), 32'(mcnt % 65536));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_result = 32'h0; in_overflow = 1'b0; in_underflow = 1'b0;
        out_ready = 1'b0; clear_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_result", a_out_result, 32'h0);
        check("rst_count", 32'(b_count), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Plain pass-through and counter.
        put(1, 32'h3FC00000, 0, 0, 1, 0); tick();
        check("pass_valid", 32'(a_out_valid), 32'd1);
        check("pass_result", a_out_result, 32'h3FC00000);
        check("pass_flags", 32'(a_out_flags), 32'd0);
        put(0, 32'h0, 0, 0, 1, 0); tick();
        check("pass_count", 32'(a_count), 32'd1);

        // Overflow saturation and sticky hold.
        put(1, 32'hC0000000, 1, 0, 1, 0); tick();
        check("ovf_result", a_out_result, 32'hFF800000);
        check("ovf_flags", 32'(a_out_flags), 32'd2);
        check("ovf_sticky", 32'(a_sto), 32'd1);
        put(0, 32'h0, 0, 0, 1, 0); tick(); tick(); tick();
        check("ovf_sticky_held", 32'(b_sto), 32'd1);

        // Underflow: flushed vs passed through.
        put(1, 32'h00400001, 0, 1, 1, 0); tick();
        check("unf_flush_result", a_out_result, 32'h00000000);
        check("unf_pass_result", b_out_result, 32'h00400001);
        check("unf_flags_a", 32'(a_out_flags), 32'd1);
        check("unf_flags_b", 32'(b_out_flags), 32'd1);

        // Set beats clear, then clear alone.
        put(1, 32'h40000000, 1, 0, 1, 1); tick();
        check("set_beats_clear", 32'(a_sto), 32'd1);
        put(0, 32'h0, 0, 0, 1, 1); tick();
        check("clear_ovf", 32'(a_sto), 32'd0);
        check("clear_unf", 32'(a_stu), 32'd0);
        check("count_4", 32'(b_count), 32'd4);

        // Back-pressure fills both slots, then drains in order.
        put(1, 32'h1, 0, 0, 0, 0); tick();
        check("bp_ready_one", 32'(a_in_ready), 32'd1);
        put(1, 32'h2, 0, 0, 0, 0); tick();
        check("bp_ready_two", 32'(a_in_ready), 32'd0);
        check("bp_hold_a", a_out_result, 32'h1);
        put(0, 32'h0, 0, 0, 0, 0); tick();
        check("bp_still_a", a_out_result, 32'h1);
        put(0, 32'h0, 0, 0, 1, 0); tick();
        check("bp_then_b", a_out_result, 32'h2);
        check("bp_ready_back", 32'(a_in_ready), 32'd1);
        put(0, 32'h0, 0, 0, 1, 0); tick();
        check("bp_empty", 32'(a_out_valid), 32'd0);
        check("bp_count", 32'(b_count), 32'd6);

        // Mixed traffic; producer holds data stable while stalled.
        for (int i = 0; i < 60; i++) begin
            if (in_valid && mq.size() == 2)
                put(in_valid, in_result, in_overflow, in_underflow, (i % 3) != 0, 0);
            else
                put((i % 4) != 1, 32'h40000000 + 32'(i) * 32'h11, (i % 5) == 2,
                    (i % 7) == 3, (i % 3) != 0, (i % 11) == 5);
            tick();
        end
        put(0, 32'h0, 0, 0, 1, 0); tick(); tick(); tick();

        // Counter wrap on a fresh reset: 17 deliveries.
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            put(1, 32'h3F800000 + 32'(i), 0, 0, 1, 0); tick();
        end
        put(0, 32'h0, 0, 0, 1, 0); tick();
        check("wrap_count_4b", 32'(a_count), 32'd1);
        check("wrap_count_16b", 32'(b_count), 32'd17);

        // Asynchronous reset while both slots are full.
        put(1, 32'hA, 0, 0, 0, 0); tick();
        put(1, 32'hB, 1, 1, 0, 0); tick();
        check("pre_rst_full", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(a_out_valid), 32'd0);
        check("arst_count", 32'(a_count), 32'd0);
        check("arst_result", a_out_result, 32'h0);
        check("arst_in_ready", 32'(a_in_ready), 32'd1);
        check("arst_sticky", 32'(a_sto), 32'd0);
        put(0, 32'h0, 0, 0, 1, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        tick(); tick();
        check("no_stale_out", 32'(a_out_valid), 32'd0);
        check("no_stale_count", 32'(b_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
